// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes, state encoding and default width
// shared by the divide sequencer and its datapath step.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] OP_DIVU = 6'd27;
    localparam logic [5:0] OP_DIV  = 6'd26;
    localparam logic [5:0] OP_MFHI = 6'd16;
    localparam logic [5:0] OP_MFLO = 6'd18;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration,
// producing the next partial remainder and quotient.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    logic           ge;

    // rem < dvs holds, so the W+1-bit difference sign is exact
    assign sh    = {rem, quo[WIDTH-1]};
    assign trial = sh - {1'b0, dvs};
    assign ge    = !trial[WIDTH];
    assign rem_n = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: restoring-divider control and HI/LO owner.
// Define DIV_SIGNED_EN to also accept signed DIV.
module div_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             flush,
    output logic             ack,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             is_muldiv;

`ifdef DIV_SIGNED_EN
    logic sgn_op;
    logic neg_q;
    logic neg_r;

    // divide magnitudes, then restore signs on commit
    assign sgn_op = (op == OP_DIV);
    assign is_div = (op == OP_DIVU) || sgn_op;
    assign mag_a  = (sgn_op && dataA[WIDTH-1]) ? -dataA : dataA;
    assign mag_b  = (sgn_op && dataB[WIDTH-1]) ? -dataB : dataB;
    assign res_lo = neg_q ? -quo_n : quo_n;
    assign res_hi = neg_r ? -rem_n : rem_n;
`else
    assign is_div = (op == OP_DIVU);
    assign mag_a  = dataA;
    assign mag_b  = dataB;
    assign res_lo = quo_n;
    assign res_hi = rem_n;
`endif

    assign is_muldiv = is_div || (op == OP_MFHI) || (op == OP_MFLO);
    assign busy      = (state != IDLE);
    assign ack       = start && is_div && !flush && (state == IDLE);
    assign stall     = start && is_muldiv && (state == RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dvs   (dvs),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            dbz   <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
`ifdef DIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ack) begin
                        if (dataB == '0) begin
                            hi    <= dataA;
                            lo    <= '1;
                            dbz   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= mag_a;
                            dvs   <= mag_b;
                            cnt   <= '0;
                            state <= RUN;
`ifdef DIV_SIGNED_EN
                            neg_q <= sgn_op && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                            neg_r <= sgn_op && dataA[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_n;
                        quo <= quo_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            hi    <= res_hi;
                            lo    <= res_lo;
                            dbz   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized scoreboard bench for div_sequencer
// against an arithmetic reference of divide results and timing.
module tb_div_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         flush;
    logic         ack;
    logic         busy;
    logic         stall;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .dataA (dataA),
        .dataB (dataB),
        .flush (flush),
        .ack   (ack),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           passed = 0;
    int           total = 0;
    int           busy_due = -1;
    logic [W-1:0] commit_hi = '0;
    logic [W-1:0] commit_lo = '0;
    logic [W-1:0] pend_hi = '0;
    logic [W-1:0] pend_lo = '0;

    function automatic exp_t ref_div(input logic [5:0] o,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sd;
        longint q;
        longint r;
        e.due = 0;
        if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
        end else if (o == OP_DIV) begin
            sa    = longint'($signed(a));
            sd    = longint'($signed(b));
            q     = sa / sd;
            r     = sa % sd;
            e.lo  = q[W-1:0];
            e.hi  = r[W-1:0];
            e.dbz = 1'b0;
        end else begin
            e.lo  = a / b;
            e.hi  = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h at cycle %0d",
                      name, act, exp, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int acc);
        bit   dv;
        bit   md;
        bit   fin;
        bit   held;
        exp_t e;
        dv    = (o == OP_DIVU) || (SIGNED_EN && o == OP_DIV);
        md    = dv || (o == OP_MFHI) || (o == OP_MFLO);
        acc   = -1;
        start = 1'b1;
        op    = o;
        dataA = a;
        dataB = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            held = md && (cyc < busy_due);
            check("ack", W'(ack), W'(dv && cyc > busy_due));
            check("stall", W'(stall), W'(held));
            fin = 1'b0;
            if (dv && cyc > busy_due) begin
                e     = ref_div(o, a, b);
                e.due = cyc + ((b == '0) ? 1 : W + 1);
                sb.push_back(e);
                busy_due = e.due;
                pend_hi  = e.hi;
                pend_lo  = e.lo;
                acc      = cyc;
                fin      = 1'b1;
            end else if (!dv && !held) begin
                if (md && cyc == busy_due) begin
                    check("mf_hi", hi, pend_hi);
                    check("mf_lo", lo, pend_lo);
                end
                fin = 1'b1;
            end
            @(posedge clk);
            #1;
            if (fin) break;
        end
        start = 1'b0;
        op    = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            idle(1);
        end
        check("drain", W'(sb.size()), '0);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL done: unexpected pulse at cycle %0d, required none",
                         cyc);
            end else begin
                mon_e = sb.pop_front();
                check("lo", lo, mon_e.lo);
                check("hi", hi, mon_e.hi);
                check("dbz", W'(dbz), W'(mon_e.dbz));
                check("done_cycle", W'(cyc), W'(mon_e.due));
                commit_hi = mon_e.hi;
                commit_lo = mon_e.lo;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int           acc;
        int           mf_acc;
        int           sel;
        logic [5:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        dataA = '0;
        dataB = '0;
        idle(2);
        @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_dbz", W'(dbz), '0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_stall", W'(stall), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(OP_DIVU, 32'd100, 32'd7, acc);
        @(negedge clk);
        check("busy_after_accept", W'(busy), 32'd1);
        idle(1);
        drain();

        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, acc);
        issue(OP_DIVU, 32'd5, 32'd0, acc);
        drain();

        issue(OP_DIVU, 32'd9, 32'd4, acc);
        idle(2);
        issue(OP_MFHI, '0, '0, mf_acc);
        drain();
        idle(1);

        start = 1'b1;
        op    = OP_DIVU;
        flush = 1'b1;
        dataA = 32'd3;
        dataB = 32'd1;
        @(negedge clk);
        check("flush_idle_ack", W'(ack), '0);
        idle(1);
        start = 1'b0;
        flush = 1'b0;

        issue(OP_DIVU, 32'd1000, 32'd3, acc);
        while (cyc < acc + 10) idle(1);
        flush = 1'b1;
        void'(sb.pop_back());
        busy_due = cyc;
        idle(1);
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", W'(busy), '0);
        check("flush_hi", hi, commit_hi);
        check("flush_lo", lo, commit_lo);
        idle(1);

        issue(OP_DIVU, 32'd50, 32'd5, acc);
        issue(OP_DIV, -32'sd7, 32'd2, acc);
        drain();

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0: b = '0;
                1: a = '0;
                2: b = 32'h8000_0000;
                3: begin
                    a = $urandom_range(0, 1000);
                    b = $urandom_range(1001, 100000);
                end
                4: b = $urandom_range(1, 16);
                default: ;
            endcase
            o = (SIGNED_EN && $urandom_range(0, 3) == 0) ? OP_DIV : OP_DIVU;
            issue(o, a, b, acc);
        end
        drain();
        idle(1);

        issue(OP_DIVU, 32'd12345, 32'd67, acc);
        while (cyc < acc + 20) idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        sb.delete();
        busy_due  = cyc - 1;
        commit_hi = '0;
        commit_lo = '0;
        @(negedge clk);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_done", W'(done), '0);
        check("mid_rst_dbz", W'(dbz), '0);
        check("mid_rst_hi", hi, '0);
        check("mid_rst_lo", lo, '0);
        idle(1);

        issue(OP_DIVU, 32'd77, 32'd8, acc);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
